sysid_check_master: RTL and testbench



---
 rtl/sysid_check_master.sv | 201 ++++++++++++++++++++
 tb/tb_sysid_check_master.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sysid_check_master.sv
// sysid_check_master: Avalon-MM read master that fetches the system ID word and
// the build timestamp word from the sysid slave, compares both against the
// values baked in at build time, and reports pass / fail / timeout.
// Every output is driven straight from a register.
module sysid_check_master #(
  parameter logic [31:0] EXPECTED_ID        = 32'd0,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1687712002,
  parameter int unsigned TIMEOUT_CYCLES     = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        address,
  output logic        read,
  input  logic        waitrequest,
  input  logic [31:0] readdata,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        timeout,
  output logic        id_match,
  output logic        ts_match,
  output logic [31:0] id_value,
  output logic [31:0] timestamp_value
);

  localparam int          DATA_W    = 32;
  localparam int          CNT_W     = 16;
  localparam logic [CNT_W-1:0] TMO_LIMIT = CNT_W'(TIMEOUT_CYCLES);
  localparam bit          TMO_EN    = (TIMEOUT_CYCLES != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ID,
    S_RD_TS,
    S_CHECK,
    S_FINISH
  } state_t;

  state_t              r_state;
  state_t              w_next;

  logic [CNT_W-1:0]    r_wait_cnt;
  logic                r_read;
  logic                r_address;
  logic                r_busy;
  logic                r_done;
  logic                r_pass;
  logic                r_timeout;
  logic                r_id_match;
  logic                r_ts_match;
  logic [DATA_W-1:0]   r_id_value;
  logic [DATA_W-1:0]   r_ts_value;

  logic                w_in_rd;
  logic                w_xfer;
  logic                w_tmo;

  // Wait counter increment that sticks at all-ones; with the timeout
  // disabled a permanently stalled slave must not wrap the counter.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  // Full-width unsigned equality used for both word checks.
  function automatic logic word_eq(input logic [DATA_W-1:0] a,
                                   input logic [DATA_W-1:0] b);
    return (a == b);
  endfunction

  // A read is outstanding exactly while the FSM sits in one of the RD states,
  // which is also when the registered read strobe is high.
  assign w_in_rd = (r_state == S_RD_ID) || (r_state == S_RD_TS);
  assign w_xfer  = w_in_rd && !waitrequest;
  // Abandon the read on the edge where the stall count has already reached
  // the limit and the slave is still stalling.
  assign w_tmo   = TMO_EN && w_in_rd && waitrequest && (r_wait_cnt == TMO_LIMIT);

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic for the check sequence.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next = S_RD_ID;
        end
      end
      S_RD_ID: begin
        if (w_tmo) begin
          w_next = S_FINISH;
        end else if (w_xfer) begin
          w_next = S_RD_TS;
        end
      end
      S_RD_TS: begin
        if (w_tmo) begin
          w_next = S_FINISH;
        end else if (w_xfer) begin
          w_next = S_CHECK;
        end
      end
      S_CHECK:  w_next = S_FINISH;
      S_FINISH: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Bus strobes and status flags, registered from the next state so they
  // line up with the state they describe.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_read    <= 1'b0;
      r_address <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_read <= (w_next == S_RD_ID) || (w_next == S_RD_TS);
      r_busy <= (w_next != S_IDLE);
      // done is high for the single cycle after FINISH, alongside pass.
      r_done <= (r_state == S_FINISH);
      // Address only moves at the start of a check or when the ID read
      // completes, so it never glitches during a stalled transfer.
      if ((r_state == S_IDLE) && start) begin
        r_address <= 1'b0;
      end else if ((r_state == S_RD_ID) && w_xfer) begin
        r_address <= 1'b1;
      end
    end
  end

  // Wait counter, captured words and compare results.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wait_cnt <= '0;
      r_pass     <= 1'b0;
      r_timeout  <= 1'b0;
      r_id_match <= 1'b0;
      r_ts_match <= 1'b0;
      r_id_value <= '0;
      r_ts_value <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_wait_cnt <= '0;
            r_pass     <= 1'b0;
            r_timeout  <= 1'b0;
            r_id_match <= 1'b0;
            r_ts_match <= 1'b0;
          end
        end
        S_RD_ID, S_RD_TS: begin
          if (w_tmo) begin
            r_timeout  <= 1'b1;
            r_pass     <= 1'b0;
            r_id_match <= 1'b0;
            r_ts_match <= 1'b0;
          end else if (w_xfer) begin
            r_wait_cnt <= '0;
            if (r_state == S_RD_ID) begin
              r_id_value <= readdata;
            end else begin
              r_ts_value <= readdata;
            end
          end else begin
            r_wait_cnt <= sat_inc(r_wait_cnt);
          end
        end
        S_CHECK: begin
          r_id_match <= word_eq(r_id_value, EXPECTED_ID);
          r_ts_match <= word_eq(r_ts_value, EXPECTED_TIMESTAMP);
          r_pass     <= word_eq(r_id_value, EXPECTED_ID) &&
                        word_eq(r_ts_value, EXPECTED_TIMESTAMP);
        end
        default: begin
        end
      endcase
    end
  end

  assign address         = r_address;
  assign read            = r_read;
  assign busy            = r_busy;
  assign done            = r_done;
  assign pass            = r_pass;
  assign timeout         = r_timeout;
  assign id_match        = r_id_match;
  assign ts_match        = r_ts_match;
  assign id_value        = r_id_value;
  assign timestamp_value = r_ts_value;

endmodule

// File: tb/tb_sysid_check_master.sv
// Directed bench for sysid_check_master: a default-parameter instance with a
// small sysid slave model, plus instances with TIMEOUT_CYCLES of 4 and 0 whose
// slaves stall forever.
module tb_sysid_check_master;

  logic        clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset;
  logic [31:0] id_word, ts_word;

  // Main instance.
  logic        start, waitrequest, address, read, busy, done, pass, timeout;
  logic        id_match, ts_match;
  logic [31:0] readdata, id_value, timestamp_value;

  // TIMEOUT_CYCLES = 4 instance.
  logic        start4, wr4, address4, read4, busy4, done4, pass4, timeout4;
  logic        id_match4, ts_match4;
  logic [31:0] rdata4, id_value4, ts_value4;

  // TIMEOUT_CYCLES = 0 instance.
  logic        start0, wr0, address0, read0, busy0, done0, pass0, timeout0;
  logic        id_match0, ts_match0;
  logic [31:0] rdata0, id_value0, ts_value0;

  int n_assert = 0;
  int n_fail   = 0;

  // Sysid slave: word 0 is the ID, word 1 the timestamp.
  assign readdata = address ? ts_word : id_word;

  sysid_check_master dut (
    .clock(clock), .reset(reset), .start(start), .address(address), .read(read),
    .waitrequest(waitrequest), .readdata(readdata), .busy(busy), .done(done),
    .pass(pass), .timeout(timeout), .id_match(id_match), .ts_match(ts_match),
    .id_value(id_value), .timestamp_value(timestamp_value));

  sysid_check_master #(.TIMEOUT_CYCLES(4)) dut_t4 (
    .clock(clock), .reset(reset), .start(start4), .address(address4), .read(read4),
    .waitrequest(wr4), .readdata(rdata4), .busy(busy4), .done(done4),
    .pass(pass4), .timeout(timeout4), .id_match(id_match4), .ts_match(ts_match4),
    .id_value(id_value4), .timestamp_value(ts_value4));

  sysid_check_master #(.TIMEOUT_CYCLES(0)) dut_t0 (
    .clock(clock), .reset(reset), .start(start0), .address(address0), .read(read0),
    .waitrequest(wr0), .readdata(rdata0), .busy(busy0), .done(done0),
    .pass(pass0), .timeout(timeout0), .id_match(id_match0), .ts_match(ts_match0),
    .id_value(id_value0), .timestamp_value(ts_value0));

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Start one check on the main instance and run it with `stall` waitrequest
  // cycles in front of each read; lat = edges from the start edge to done.
  task automatic run_check(input int stall, output int lat, output int ndone,
                           output bit addr_ok);
    int   sc;
    bit   prev_stall, prev_xfer;
    logic prev_addr;
    sc = 0; lat = -1; ndone = 0; addr_ok = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      waitrequest = (read === 1'b1) && (sc < stall);
      prev_stall  = (read === 1'b1) && waitrequest;
      prev_xfer   = (read === 1'b1) && !waitrequest;
      prev_addr   = address;
      step();
      if (prev_stall) begin
        sc++;
        if (read !== 1'b1 || address !== prev_addr) addr_ok = 1'b0;
      end
      if (prev_xfer) sc = 0;
      if (done === 1'b1) begin
        ndone++;
        if (lat < 0) lat = c;
      end
      if (lat >= 0 && c >= lat + 2) break;
    end
    waitrequest = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; start4 = 1'b0; start0 = 1'b0;
    waitrequest = 1'b0; wr4 = 1'b0; wr0 = 1'b0;
    step(); step();
    reset = 1'b0;
    n_assert++;
    if ({address, read, busy, done, pass, timeout, id_match, ts_match} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_flags: got %b, want 00000000",
               {address, read, busy, done, pass, timeout, id_match, ts_match});
    end
    n_assert++;
    if (id_value !== 32'h0 || timestamp_value !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_words: got id=%h ts=%h, want 0/0", id_value, timestamp_value);
    end
    n_assert++;
    if ({read4, busy4, read0, busy0} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_aux: got %b, want 0000", {read4, busy4, read0, busy0});
    end
  endtask

  task automatic test_zero_wait();
    id_word = 32'h0; ts_word = 32'h64987102;
    start = 1'b1;
    step();
    start = 1'b0;
    n_assert++;
    if ({read, address, busy} !== 3'b101) begin
      n_fail++;
      $display("FAIL zw_rd_id: read/addr/busy got %b, want 101", {read, address, busy});
    end
    step();
    n_assert++;
    if ({read, address} !== 2'b11) begin
      n_fail++;
      $display("FAIL zw_rd_ts: read/addr got %b, want 11", {read, address});
    end
    step();
    n_assert++;
    if (read !== 1'b0 || timestamp_value !== 32'h64987102) begin
      n_fail++;
      $display("FAIL zw_capture: read=%b ts=%h, want 0 / 64987102", read, timestamp_value);
    end
    step();
    n_assert++;
    if (done !== 1'b0 || pass !== 1'b1) begin
      n_fail++;
      $display("FAIL zw_check: done=%b pass=%b, want 0/1", done, pass);
    end
    step();
    n_assert++;
    if ({done, pass, id_match, ts_match, timeout, busy} !== 6'b111100) begin
      n_fail++;
      $display("FAIL zw_done: done/pass/idm/tsm/tmo/busy got %b, want 111100",
               {done, pass, id_match, ts_match, timeout, busy});
    end
    step();
    n_assert++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL zw_done_pulse: done=%b one cycle later, want 0", done);
    end
  endtask

  task automatic test_id_mismatch();
    int lat, nd; bit aok;
    id_word = 32'h00000001; ts_word = 32'h64987102;
    run_check(0, lat, nd, aok);
    n_assert++;
    if (lat !== 4 || nd !== 1) begin
      n_fail++;
      $display("FAIL mm_latency: lat=%0d dones=%0d, want 4/1", lat, nd);
    end
    n_assert++;
    if ({id_match, ts_match, pass, timeout} !== 4'b0100) begin
      n_fail++;
      $display("FAIL mm_flags: idm/tsm/pass/tmo got %b, want 0100",
               {id_match, ts_match, pass, timeout});
    end
    n_assert++;
    if (id_value !== 32'h00000001) begin
      n_fail++;
      $display("FAIL mm_id_value: got %h, want 00000001", id_value);
    end
    id_word = 32'h0;
  endtask

  task automatic test_stall();
    int lat, nd; bit aok;
    run_check(3, lat, nd, aok);
    n_assert++;
    if (lat !== 10 || nd !== 1) begin
      n_fail++;
      $display("FAIL stall_latency: lat=%0d dones=%0d, want 10/1", lat, nd);
    end
    n_assert++;
    if (aok !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_addr_stable: got %b, want 1", aok);
    end
    n_assert++;
    if ({pass, timeout} !== 2'b10) begin
      n_fail++;
      $display("FAIL stall_result: pass/tmo got %b, want 10", {pass, timeout});
    end
  endtask

  task automatic test_timeout();
    bit rd_ok;
    int nd;
    rdata4 = 32'hDEADBEEF;
    start4 = 1'b1; wr4 = 1'b1;
    step();
    start4 = 1'b0;
    rd_ok = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      step();
      if (read4 !== 1'b1 || address4 !== 1'b0) rd_ok = 1'b0;
    end
    n_assert++;
    if (rd_ok !== 1'b1) begin
      n_fail++;
      $display("FAIL tmo_read_held: read not held for 4 stall edges (got %b, want 1)", rd_ok);
    end
    step();
    n_assert++;
    if ({read4, timeout4, pass4, done4, busy4, id_match4, ts_match4} !== 7'b0100100) begin
      n_fail++;
      $display("FAIL tmo_edge: rd/tmo/pass/done/busy/idm/tsm got %b, want 0100100",
               {read4, timeout4, pass4, done4, busy4, id_match4, ts_match4});
    end
    step();
    n_assert++;
    if ({done4, busy4, timeout4} !== 3'b101) begin
      n_fail++;
      $display("FAIL tmo_done: done/busy/tmo got %b, want 101", {done4, busy4, timeout4});
    end
    nd = 1;
    for (int c = 0; c < 5; c++) begin
      step();
      if (done4 === 1'b1) nd++;
    end
    n_assert++;
    if (nd !== 1) begin
      n_fail++;
      $display("FAIL tmo_single_done: got %0d done pulses, want 1", nd);
    end
    n_assert++;
    if (id_value4 !== 32'h0) begin
      n_fail++;
      $display("FAIL tmo_no_capture: id_value=%h, want 00000000", id_value4);
    end
    wr4 = 1'b0;
  endtask

  task automatic test_no_timeout();
    int nd;
    rdata0 = 32'h12345678;
    start0 = 1'b1; wr0 = 1'b1;
    step();
    start0 = 1'b0;
    nd = 0;
    for (int c = 0; c < 1000; c++) begin
      step();
      if (done0 === 1'b1) nd++;
    end
    n_assert++;
    if ({busy0, read0, timeout0} !== 3'b110 || nd !== 0) begin
      n_fail++;
      $display("FAIL t0_never_times_out: busy/read/tmo got %b dones=%0d, want 110/0",
               {busy0, read0, timeout0}, nd);
    end
  endtask

  task automatic test_start_ignored();
    int nd, first;
    nd = 0; first = -1;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 3; c <= 15; c++) begin
      step();
      if (done === 1'b1) begin
        nd++;
        if (first < 0) first = c;
      end
    end
    n_assert++;
    if (nd !== 1 || first !== 4) begin
      n_fail++;
      $display("FAIL start_ignored: dones=%0d first=%0d, want 1/4", nd, first);
    end
    n_assert++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL start_ignored_idle: busy=%b, want 0", busy);
    end
  endtask

  task automatic test_back_to_back();
    int at[3];
    int nd;
    nd = 0;
    at[0] = -1; at[1] = -1; at[2] = -1;
    start = 1'b1;
    step();
    for (int c = 1; c <= 14; c++) begin
      step();
      if (done === 1'b1) begin
        if (nd < 3) at[nd] = c;
        nd++;
      end
    end
    start = 1'b0;
    n_assert++;
    if (nd !== 3 || at[0] !== 4 || at[1] !== 9 || at[2] !== 14) begin
      n_fail++;
      $display("FAIL b2b_spacing: dones=%0d at %0d,%0d,%0d, want 3 at 4,9,14",
               nd, at[0], at[1], at[2]);
    end
    for (int c = 0; c < 20; c++) begin
      if (busy === 1'b0) break;
      step();
    end
    step();
    n_assert++;
    if (busy !== 1'b0 || pass !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_settle: busy/pass got %b, want 01", {busy, pass});
    end
  endtask

  task automatic test_reset_mid();
    int nd, lat; bit aok;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    n_assert++;
    if ({read, address, busy} !== 3'b111) begin
      n_fail++;
      $display("FAIL rst_mid_pre: read/addr/busy got %b, want 111", {read, address, busy});
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_assert++;
    if ({address, read, busy, done, pass, timeout, id_match, ts_match} !== 8'h00 ||
        timestamp_value !== 32'h0 || id_value !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_mid_clear: flags=%b id=%h ts=%h, want all zero",
               {address, read, busy, done, pass, timeout, id_match, ts_match},
               id_value, timestamp_value);
    end
    nd = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (done === 1'b1) nd++;
    end
    n_assert++;
    if (nd !== 0) begin
      n_fail++;
      $display("FAIL rst_mid_no_done: got %0d done pulses, want 0", nd);
    end
    run_check(0, lat, nd, aok);
    n_assert++;
    if (lat !== 4 || pass !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid_recheck: lat=%0d pass=%b, want 4/1", lat, pass);
    end
  endtask

  initial begin
    id_word = 32'h0; ts_word = 32'h64987102;
    rdata4 = 32'h0; rdata0 = 32'h0;
    test_reset();
    test_zero_wait();
    test_id_mismatch();
    test_stall();
    test_timeout();
    test_no_timeout();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
